// File: rtl/cordic_mac_seq.sv
// cordic_mac_seq: iterative linear-mode CORDIC MAC (y = acc + x*z), one shared add_sub; define CORDIC_EARLY_TERM_EN to stop once z reaches 0
module add_sub #(
    parameter int WIDTH = 15
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    input  logic           sel,
    output logic [WIDTH:0] result
);
    logic [WIDTH+1:0] sum;
    // widened add/subtract; keep the true sign and drop magnitude bit WIDTH on overflow
    always_comb begin
        sum = sel ? {a[WIDTH], a} - {b[WIDTH], b} : {a[WIDTH], a} + {b[WIDTH], b};
        result = {sum[WIDTH+1], sum[WIDTH-1:0]};
    end
endmodule

module cordic_mac_seq #(
    parameter int WIDTH = 15,
    parameter int FRAC  = 12,
    parameter int ITER  = 13
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [WIDTH:0] x_in,
    input  logic [WIDTH:0] z_in,
    input  logic [WIDTH:0] acc_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [WIDTH:0] y_out,
    output logic           busy
);
    localparam int IW = $clog2(FRAC + 2);

    if (ITER < 1 || ITER > FRAC + 1) begin : g_bad_iter
        $error("cordic_mac_seq: ITER must lie in 1..FRAC+1");
    end

    typedef enum logic [1:0] {IDLE, Y_OP, Z_OP, DONE} state_t;

    state_t                state, nxt;
    logic signed [WIDTH:0] x;
    logic [WIDTH:0]        y, z;
    logic [IW-1:0]         i;
    logic [WIDTH:0]        xs, step, op_a, op_b, res;
    logic                  op_sel, term;

    add_sub #(.WIDTH(WIDTH)) u_add_sub (
        .a      (op_a),
        .b      (op_b),
        .sel    (op_sel),
        .result (res)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // operand steering for the shared adder, termination test, next state and handshake outputs
    always_comb begin
        xs        = x >>> i;
        step      = {{WIDTH{1'b0}}, 1'b1} << (IW'(FRAC) - i);
        op_a      = (state == Z_OP) ? z : y;
        op_b      = (state == Z_OP) ? step : xs;
        op_sel    = (state == Z_OP) ? ~z[WIDTH] : z[WIDTH];
        term      = (i == IW'(ITER - 1));
`ifdef CORDIC_EARLY_TERM_EN
        term      = term || (res == '0);
`else
        term      = term;
`endif
        nxt       = (state == IDLE) ? (in_valid ? Y_OP : IDLE) :
                    (state == Y_OP) ? Z_OP :
                    (state == Z_OP) ? (term ? DONE : Y_OP) :
                    (out_ready ? IDLE : DONE);
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == Y_OP) || (state == Z_OP);
        y_out     = y;
    end

    // datapath: capture operands, y-update in Y_OP, z-update and iteration advance in Z_OP
    always_ff @(posedge clk) begin
        if (rst) begin
            x <= '0;
            y <= '0;
            z <= '0;
            i <= '0;
        end else begin
            if (state == IDLE && in_valid) begin
                x <= x_in;
                y <= acc_in;
                z <= z_in;
                i <= '0;
            end
            if (state == Y_OP) y <= res;
            if (state == Z_OP) begin
                z <= res;
                if (!term) i <= i + IW'(1);
            end
        end
    end
endmodule

// File: tb/tb_cordic_mac_seq.sv
// tb_cordic_mac_seq: table vectors, handshake corner cases and random jobs against a plain-arithmetic CORDIC model
module tb_cordic_mac_seq;
    localparam int WIDTH = 15;
    localparam int FRAC  = 12;
    localparam int ITER  = 13;

    logic        clk = 0;
    logic        rst = 1;
    logic        in_valid = 0;
    logic        in_ready;
    logic [15:0] x_in = '0;
    logic [15:0] z_in = '0;
    logic [15:0] acc_in = '0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [15:0] y_out;
    logic        busy;

    int n_checks = 0;
    int n_fail = 0;

    cordic_mac_seq #(.WIDTH(WIDTH), .FRAC(FRAC), .ITER(ITER)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .z_in      (z_in),
        .acc_in    (acc_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_out     (y_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int z;
        int acc;
        int exp_y;
        int exp_lat;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int wrap(input int s);
        int lo;
        lo = s & 32'h7FFF;
        return (s < 0) ? lo - 32768 : lo;
    endfunction

    function automatic void model(input int x, input int z, input int acc, output int y, output int lat);
        int zz;
        int dx;
        int dz;
        y = acc;
        zz = z;
        lat = 0;
        for (int k = 0; k < ITER; k++) begin
            dx = x >>> k;
            dz = 1 << (FRAC - k);
            if (zz >= 0) begin
                y = wrap(y + dx);
                zz = wrap(zz - dz);
            end else begin
                y = wrap(y - dx);
                zz = wrap(zz + dz);
            end
            lat = 2 * (k + 1);
`ifdef CORDIC_EARLY_TERM_EN
            if (zz == 0) break;
`endif
        end
    endfunction

    task automatic run_job(input int x, input int z, input int acc, output int y, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        x_in = 16'(x);
        z_in = 16'(z);
        acc_in = 16'(acc);
        in_valid = 1;
        @(posedge clk);
        #1;
        in_valid = 0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        y = int'($signed(y_out));
    endtask

    task automatic drain();
        out_ready = 1;
        @(posedge clk);
        #1;
        out_ready = 0;
    endtask

    vec_t vecs[3];
    int y;
    int lat;
    int ey;
    int elat;
    int rx;
    int rz;
    int racc;
    int got_y[$];
    int got_c[$];
    int jx[3];
    int jz[3];
    int ja[3];
    int jn;
    bit acc_next;

    initial begin
`ifdef CORDIC_EARLY_TERM_EN
        vecs[0] = '{4096, 2048, 0, 2048, 4};
        vecs[1] = '{4096, -2048, 0, -2048, 4};
        vecs[2] = '{4096, 2048, 31000, 280, 4};
`else
        vecs[0] = '{4096, 2048, 0, 2049, 26};
        vecs[1] = '{4096, -2048, 0, -2047, 26};
        vecs[2] = '{4096, 2048, 31000, 281, 26};
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_y_out", int'(y_out), 0);
        rst = 0;

        for (int v = 0; v < 3; v++) begin
            run_job(vecs[v].x, vecs[v].z, vecs[v].acc, y, lat);
            chk($sformatf("vec%0d_y", v), y, vecs[v].exp_y);
            chk($sformatf("vec%0d_latency", v), lat, vecs[v].exp_lat);
            drain();
        end

        run_job(4096, 2048, 0, y, lat);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                x_in = 16'(100);
                z_in = 16'(300);
                acc_in = 16'(7);
                in_valid = 1;
            end
            @(posedge clk);
            #1;
            in_valid = 0;
            chk("stall_out_valid", int'(out_valid), 1);
            chk("stall_y_out", int'($signed(y_out)), vecs[0].exp_y);
            chk("stall_in_ready", int'(in_ready), 0);
        end
        drain();
        chk("drain_out_valid", int'(out_valid), 0);
        chk("drain_in_ready", int'(in_ready), 1);
        chk("drain_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        chk("drain_idle_busy", int'(busy), 0);

        x_in = 16'(4096);
        z_in = 16'(1234);
        acc_in = 16'(0);
        in_valid = 1;
        @(posedge clk);
        #1;
        in_valid = 0;
        repeat (9) @(posedge clk);
        #1;
        chk("midjob_busy", int'(busy), 1);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_y_out", int'(y_out), 0);
        chk("abort_busy", int'(busy), 0);
        run_job(4096, 2048, 0, y, lat);
        chk("after_abort_y", y, vecs[0].exp_y);
        drain();

        for (int r = 0; r < 20; r++) begin
            rx = int'($urandom_range(0, 65535)) - 32768;
            rz = int'($urandom_range(0, 16382)) - 8191;
            racc = int'($urandom_range(0, 65535)) - 32768;
            if (r == 0) rz = 0;
            model(rx, rz, racc, ey, elat);
            run_job(rx, rz, racc, y, lat);
            chk($sformatf("rand%0d_y", r), y, ey);
            chk($sformatf("rand%0d_latency", r), lat, elat);
            drain();
        end

        jx = '{4096, 4096, 4096};
        jz = '{2048, -2048, 2048};
        ja = '{0, 0, 31000};
        jn = 0;
        x_in = 16'(jx[0]);
        z_in = 16'(jz[0]);
        acc_in = 16'(ja[0]);
        in_valid = 1;
        out_ready = 1;
        for (int c = 0; c < 120; c++) begin
            acc_next = in_ready && in_valid;
            if (out_valid) begin
                got_y.push_back(int'($signed(y_out)));
                got_c.push_back(c);
            end
            @(posedge clk);
            #1;
            if (acc_next) begin
                jn++;
                if (jn < 3) begin
                    x_in = 16'(jx[jn]);
                    z_in = 16'(jz[jn]);
                    acc_in = 16'(ja[jn]);
                end else begin
                    in_valid = 0;
                end
            end
        end
        out_ready = 0;
        in_valid = 0;
        chk("b2b_result_count", got_y.size(), 3);
        for (int j = 0; j < 3 && j < got_y.size(); j++) begin
            model(jx[j], jz[j], ja[j], ey, elat);
            chk($sformatf("b2b%0d_y", j), got_y[j], ey);
            if (j > 0) chk($sformatf("b2b%0d_spacing", j), got_c[j] - got_c[j-1], elat + 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
